// File: rtl/rabbit_rx_pkg.sv
// rabbit_rx_pkg: shared defaults and FSM state type for the Rabbit serial receiver.
package rabbit_rx_pkg;
  localparam int FRAME_BITS_DEF   = 184;
  localparam int IDLE_TIMEOUT_DEF = 10000;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} rx_state_e;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: 2-FF synchroniser for an async pin plus rising-edge detect.
// Ports:
//   i_clk    clock
//   i_rst_n  synchronous active-low reset
//   i_async  asynchronous input pin
//   o_rise   1-cycle pulse on a synchronised rising edge (2 clk after the pin)
module sync_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_rise
);
  logic [1:0] r_sync;
  logic       r_sync_d;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync   <= '0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], i_async};
      r_sync_d <= r_sync[1];
    end
  end

  assign o_rise = r_sync[1] & ~r_sync_d;
endmodule

// File: rtl/rabbit_serial_rx.sv
// rabbit_serial_rx: deserialises the bit-banged Rabbit stream (SCLK/SDIO) into one
// FRAME_BITS-wide DDS programming word, handed over with valid/ready.
// Optional feature macro: RX_PARITY_EN (adds a trailing even-parity bit per frame).
// Ports:
//   ten_MHz_ext  sole clock          rst_n       sync reset, active-low
//   sclk_in      Rabbit serial clock sdio_in     Rabbit serial data
//   frame_data   completed word, [0] = first bit received
//   frame_valid  unconsumed word held frame_ready consumer accepts
//   busy         partial frame in progress
//   short_err    1-cycle pulse, partial frame aborted by idle timeout
//   overrun      sticky, a finished frame was dropped because the old word was held
//   parity_err   1-cycle pulse on parity mismatch (0 without RX_PARITY_EN)
module rabbit_serial_rx
  import rabbit_rx_pkg::*;
#(
  parameter int FRAME_BITS   = FRAME_BITS_DEF,
  parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF
) (
  input  logic                  ten_MHz_ext,
  input  logic                  rst_n,
  input  logic                  sclk_in,
  input  logic                  sdio_in,
  output logic [0:FRAME_BITS-1] frame_data,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  busy,
  output logic                  short_err,
  output logic                  overrun,
  output logic                  parity_err
);
`ifdef RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int NBITS = FRAME_BITS + int'(PAR_EN);
  localparam int CW    = $clog2(FRAME_BITS + 2);
  localparam int TW    = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CW-1:0] C_FB   = CW'(FRAME_BITS);
  localparam logic [CW-1:0] C_NB   = CW'(NBITS);
  localparam logic [CW-1:0] C_LAST = CW'(NBITS - 1);
  localparam logic [TW-1:0] T_LAST = TW'(IDLE_TIMEOUT - 1);

  rx_state_e             r_state;
  logic [0:FRAME_BITS-1] r_shift;
  logic [0:FRAME_BITS-1] r_frame_data;
  logic [CW-1:0]         r_cnt;
  logic [TW-1:0]         r_tcnt;
  logic                  r_valid, r_short, r_ovr, r_perr;
  logic                  r_par;        // running XOR over every received bit
  logic [1:0]            r_sdio_sync;  // same depth as the SCLK path keeps data aligned
  logic                  w_rise, w_sdio, w_par_bad;

  sync_edge_det u_sclk_sync (
    .i_clk   (ten_MHz_ext),
    .i_rst_n (rst_n),
    .i_async (sclk_in),
    .o_rise  (w_rise)
  );

  assign w_sdio = r_sdio_sync[1];
  // Even parity over payload+parity bit must XOR to 0.
  assign w_par_bad = PAR_EN & r_par;

  always_ff @(posedge ten_MHz_ext) begin
    if (!rst_n) begin
      r_sdio_sync  <= '0;
      r_state      <= IDLE;
      r_shift      <= '0;
      r_frame_data <= '0;
      r_cnt        <= '0;
      r_tcnt       <= '0;
      r_par        <= 1'b0;
      r_valid      <= 1'b0;
      r_short      <= 1'b0;
      r_ovr        <= 1'b0;
      r_perr       <= 1'b0;
    end else begin
      r_sdio_sync <= {r_sdio_sync[0], sdio_in};
      r_short     <= 1'b0;
      r_perr      <= 1'b0;
      if (r_valid && frame_ready) r_valid <= 1'b0;

      case (r_state)
        SHIFT: begin
          if (w_rise) begin
            r_tcnt <= '0;
            r_par  <= r_par ^ w_sdio;
            if (r_cnt < C_FB) r_shift[r_cnt] <= w_sdio;  // parity bit is not stored
            if (r_cnt < C_NB) r_cnt <= r_cnt + CW'(1);
            if (r_cnt == C_LAST) r_state <= DONE;
          end else if (r_tcnt == T_LAST) begin
            r_short <= 1'b1;
            r_tcnt  <= '0;
            r_state <= IDLE;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        DONE: begin
          if (w_par_bad) begin
            r_perr <= 1'b1;
          end else if (!r_valid || frame_ready) begin
            // Accept of the old word and load of the new one may share this edge.
            r_frame_data <= r_shift;
            r_valid      <= 1'b1;
          end else begin
            r_ovr <= 1'b1;
          end
          // An edge here is the first bit of the next frame.
          if (w_rise) begin
            r_shift[0] <= w_sdio;
            r_cnt      <= CW'(1);
            r_par      <= w_sdio;
            r_tcnt     <= '0;
            r_state    <= SHIFT;
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          if (w_rise) begin
            r_shift[0] <= w_sdio;
            r_cnt      <= CW'(1);
            r_par      <= w_sdio;
            r_tcnt     <= '0;
            r_state    <= SHIFT;
          end
        end
      endcase
    end
  end

  assign frame_data  = r_frame_data;
  assign frame_valid = r_valid;
  assign busy        = (r_state == SHIFT);
  assign short_err   = r_short;
  assign overrun     = r_ovr;
  assign parity_err  = r_perr;
endmodule

// File: tb/tb_rabbit_serial_rx.sv
// tb_rabbit_serial_rx: directed scenarios with random payloads for rabbit_serial_rx.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_rabbit_serial_rx;
  import rabbit_rx_pkg::*;
  localparam int FB = FRAME_BITS_DEF;
  localparam int T  = IDLE_TIMEOUT_DEF;
`ifdef RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = FB + PAR;

  logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, sdio = 1'b0, ready = 1'b0;
  logic [0:FB-1] frame_data;
  logic frame_valid, busy, short_err, overrun, parity_err;

  rabbit_serial_rx dut (
    .ten_MHz_ext (clk),
    .rst_n       (rst_n),
    .sclk_in     (sclk),
    .sdio_in     (sdio),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (ready),
    .busy        (busy),
    .short_err   (short_err),
    .overrun     (overrun),
    .parity_err  (parity_err)
  );

  always #50 clk = ~clk;

  int checks = 0, errors = 0, n_short = 0, n_perr = 0;

  // Error pulses last one cycle, so each is seen exactly once here.
  always @(negedge clk) begin
    if (short_err) n_short++;
    if (parity_err) n_perr++;
  end

  // Reference model of the output word register.
  logic          m_valid = 1'b0, m_ovr = 1'b0;
  logic [0:FB-1] m_data = '0;

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [0:FB-1] rnd_word();
    logic [0:FB-1] r;
    for (int i = 0; i < FB; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  function automatic logic [0:FB] mkframe(input logic [0:FB-1] p, input bit bad);
    return {p, (^p) ^ bad};
  endfunction

  // Sends n bits; returns right after driving the final rising SCLK.
  task automatic send_bits(input logic [0:FB] w, input int n);
    for (int i = 0; i < n; i++) begin
      sclk = 1'b0;
      sdio = w[i];
      step(int'($urandom_range(2, 5)));
      sclk = 1'b1;
      if (i < n - 1) step(int'($urandom_range(2, 5)));
    end
  endtask

  task automatic model_done(input logic [0:FB-1] w, input bit rdy);
    if (!m_valid || rdy) begin
      m_data  = w;
      m_valid = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " valid"}, 256'(frame_valid), 256'(m_valid));
    chk({tag, " data"}, 256'(frame_data), 256'(m_data));
    chk({tag, " overrun"}, 256'(overrun), 256'(m_ovr));
  endtask

  // One complete frame with ready held high: word visible 4 clk after the
  // final pin rise, consumed one clk later.
  task automatic rx_ready_frame(input logic [0:FB-1] w, input string tag);
    send_bits(mkframe(w, 1'b0), NB);
    step(2);
    chk({tag, " busy"}, 256'(busy), 256'(1));
    step(1);
    chk({tag, " pre valid"}, 256'(frame_valid), 256'(m_valid));
    chk({tag, " busy done"}, 256'(busy), 256'(0));
    step(1);
    model_done(w, 1'b1);
    check_model(tag);
    step(1);
    m_valid = 1'b0;
    chk({tag, " consumed"}, 256'(frame_valid), 256'(0));
  endtask

  initial begin
    logic [0:FB-1] w, a, b;
    logic [7:0] a5;

    // Reset
    step(3);
    chk("rst valid", 256'(frame_valid), 256'(0));
    chk("rst data", 256'(frame_data), 256'(0));
    chk("rst busy", 256'(busy), 256'(0));
    chk("rst short", 256'(short_err), 256'(0));
    chk("rst overrun", 256'(overrun), 256'(0));
    chk("rst parity", 256'(parity_err), 256'(0));
    rst_n = 1'b1;
    step(2);

    // 0xA5 pattern, then random words, ready high
    ready = 1'b1;
    a5 = 8'hA5;
    for (int i = 0; i < FB; i++) w[i] = a5[7 - (i % 8)];
    rx_ready_frame(w, "a5");
    chk("a5 no short", 256'(n_short), 256'(0));
    for (int k = 0; k < 2; k++) rx_ready_frame(rnd_word(), "rand");

    // Partial frame aborted by idle timeout
    w = rnd_word();
    send_bits(mkframe(w, 1'b0), 100);
    step(T + 2);
    chk("to before", 256'(short_err), 256'(0));
    chk("to busy", 256'(busy), 256'(1));
    step(1);
    chk("to pulse", 256'(short_err), 256'(1));
    chk("to idle", 256'(busy), 256'(0));
    step(1);
    chk("to end", 256'(short_err), 256'(0));
    chk("to valid", 256'(frame_valid), 256'(0));
    chk("to count", 256'(n_short), 256'(1));
    rx_ready_frame(rnd_word(), "after to");

    // Overrun: two frames with ready low
    ready = 1'b0;
    a = rnd_word();
    b = rnd_word();
    send_bits(mkframe(a, 1'b0), NB);
    step(4);
    model_done(a, 1'b0);
    check_model("ovr first");
    send_bits(mkframe(b, 1'b0), NB);
    step(3);
    chk("ovr pre", 256'(overrun), 256'(0));
    step(1);
    model_done(b, 1'b0);
    check_model("ovr second");
    ready = 1'b1;
    step(1);
    m_valid = 1'b0;
    ready = 1'b0;
    chk("ovr drop", 256'(frame_valid), 256'(0));
    chk("ovr sticky", 256'(overrun), 256'(1));

    // Reset in the middle of a frame
    send_bits(mkframe(rnd_word(), 1'b0), 90);
    sclk = 1'b0;
    step(4);
    rst_n = 1'b0;
    step(1);
    chk("mid rst valid", 256'(frame_valid), 256'(0));
    chk("mid rst data", 256'(frame_data), 256'(0));
    chk("mid rst overrun", 256'(overrun), 256'(0));
    chk("mid rst busy", 256'(busy), 256'(0));
    rst_n = 1'b1;
    m_valid = 1'b0;
    m_ovr = 1'b0;
    m_data = '0;
    step(2);
    ready = 1'b1;
    rx_ready_frame(rnd_word(), "post rst");

    // Back-to-back: ready pulsed exactly in the DONE cycle
    ready = 1'b0;
    a = rnd_word();
    b = rnd_word();
    send_bits(mkframe(a, 1'b0), NB);
    step(4);
    model_done(a, 1'b0);
    check_model("b2b first");
    send_bits(mkframe(b, 1'b0), NB);
    step(3);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    model_done(b, 1'b1);
    check_model("b2b swap");
    step(1);
    chk("b2b hold", 256'(frame_valid), 256'(1));
    chk("b2b hold data", 256'(frame_data), 256'(b));
    ready = 1'b1;
    step(1);
    m_valid = 1'b0;
    chk("b2b drop", 256'(frame_valid), 256'(0));

`ifdef RX_PARITY_EN
    // Wrong parity discards the frame; the next good frame lands
    w = rnd_word();
    send_bits(mkframe(w, 1'b1), NB);
    step(4);
    chk("par pulse", 256'(parity_err), 256'(1));
    chk("par valid", 256'(frame_valid), 256'(0));
    step(1);
    chk("par end", 256'(parity_err), 256'(0));
    rx_ready_frame(w, "par good");
`endif

    step(5);
    chk("short total", 256'(n_short), 256'(1));
    chk("parity total", 256'(n_perr), 256'(PAR));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
